// File: rtl/mul_pipe.sv
// mul_pipe: LATENCY-stage pipelined multiplier (low, signed-high, unsigned-high) with valid/ready
// on both sides, bubble-collapsing backpressure, a tag sideband and a single-cycle flush.
package mul_pkg;
  typedef enum logic [1:0] {
    MUL_MUL   = 2'b00,
    MUL_MULH  = 2'b01,
    MUL_MULHU = 2'b10
  } mul_opcode_t;
endpackage

module mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  mul_opcode_t        opcode,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  logic                     sx;
  logic signed [WIDTH:0]    a_ext, b_ext;
  logic signed [2*WIDTH-1:0] a_wide, b_wide, product;
  logic [WIDTH-1:0]         result_in;

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] adv, load;

  // The full product is formed ahead of S1; later stages only carry it, leaving the
  // reduction free to be retimed across the stage registers.
  always_comb begin
    sx        = (opcode == MUL_MULH);
    a_ext     = signed'({sx & src1[WIDTH-1], src1});
    b_ext     = signed'({sx & src2[WIDTH-1], src2});
    a_wide    = {{(WIDTH-1){a_ext[WIDTH]}}, a_ext};
    b_wide    = {{(WIDTH-1){b_ext[WIDTH]}}, b_ext};
    product   = a_wide * b_wide;
    result_in = (opcode == MUL_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
  end

  // A stage advances when its successor is empty or itself advancing, so bubbles collapse.
  always_comb begin
    adv = '0;
    load = '0;
    adv[LATENCY-1] = valid_q[LATENCY-1] & out_ready;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
    end
    in_ready = ~valid_q[0] | adv[0];
    load[0]  = in_valid & in_ready;
    for (int k = 1; k < LATENCY; k++) begin
      load[k] = adv[k-1];
    end
    valid_d = flush ? '0 : ((valid_q & ~adv) | load);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic [WIDTH-1:0] result_d, result_q;
    logic [TAG_W-1:0] tag_d, tag_q;

    if (gi == 0) begin : g_first
      always_comb begin
        result_d = load[0] ? result_in : result_q;
        tag_d    = load[0] ? in_tag    : tag_q;
      end
    end else begin : g_next
      always_comb begin
        result_d = load[gi] ? g_stage[gi-1].result_q : result_q;
        tag_d    = load[gi] ? g_stage[gi-1].tag_q    : tag_q;
      end
    end

    // Data only changes on a load, which keeps the output stable during a stall.
    always_ff @(posedge clk) begin
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  assign out_valid  = valid_q[LATENCY-1];
  assign out_result = g_stage[LATENCY-1].result_q;
  assign out_tag    = g_stage[LATENCY-1].tag_q;
  assign busy       = |valid_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: eight instances (directed, bubble-collapse, WIDTH x LATENCY sweep), each
// checked every cycle against a queue model that tracks accepted ops and their age.
module tb_mul_pipe;
  import mul_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_done = 0;

  function automatic int w_of(int i);
    case (i)
      2, 3:    return 8;
      6, 7:    return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int l_of(int i);
    case (i)
      0:       return 2;
      1:       return 4;
      2, 4, 6: return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(int id, string nm, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h (cycle %0d)", id, nm, act, expv, cyc);
    end
  endtask

  // Reference: plain wide arithmetic on the mathematical operand values.
  function automatic logic [63:0] ref_mul(int w, logic [1:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0]         mask;
    logic signed [129:0] x, y, p, sh;
    mask = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - w);
    x = signed'({66'd0, a & mask});
    y = signed'({66'd0, b & mask});
    if (op == 2'b01) begin
      if (a[w-1]) x = x - (130'sd1 <<< w);
      if (b[w-1]) y = y - (130'sd1 <<< w);
    end
    p = x * y;
    if (op == 2'b00) return p[63:0] & mask;
    sh = p >>> w;
    return sh[63:0] & mask;
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_inst
    localparam int W = w_of(gi);
    localparam int L = l_of(gi);

    logic          reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
    mul_opcode_t   opcode;
    logic [W-1:0]  src1, src2, out_result;
    logic [4:0]    in_tag, out_tag;
    exp_t          sb[$];

    mul_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(5)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .src1      (src1),
      .src2      (src2),
      .in_tag    (in_tag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_tag   (out_tag),
      .busy      (busy)
    );

    // The oldest op never waits on anything ahead, so it is visible exactly L edges after acceptance.
    initial begin
      logic exp_ov;
      exp_t e;
      @(posedge clk);
      forever begin
        @(negedge clk);
        exp_ov = 1'b0;
        if (sb.size() > 0) exp_ov = ((cyc - sb[0].acc) >= L);
        chk(gi, "in_ready", 64'(in_ready), 64'((sb.size() < L) || out_ready));
        chk(gi, "out_valid", 64'(out_valid), 64'(exp_ov));
        chk(gi, "busy", 64'(busy), 64'(sb.size() > 0));
        if (exp_ov && out_valid) begin
          chk(gi, "out_result", 64'(out_result), sb[0].res);
          chk(gi, "out_tag", 64'(out_tag), 64'(sb[0].tag));
        end
        if (exp_ov && out_valid && out_ready) void'(sb.pop_front());
        if (reset || flush) begin
          sb.delete();
        end else if (in_valid && in_ready) begin
          e.res = ref_mul(W, opcode, 64'(src1), 64'(src2));
          e.tag = in_tag;
          e.acc = cyc;
          sb.push_back(e);
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic init_and_reset();
      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      opcode = MUL_MUL; src1 = '0; src2 = '0; in_tag = '0;
      step();
      step();
      @(negedge clk);
      chk(gi, "reset_out_valid", 64'(out_valid), 64'd0);
      chk(gi, "reset_busy", 64'(busy), 64'd0);
      chk(gi, "reset_in_ready", 64'(in_ready), 64'd1);
      step();
      reset = 1'b0;
    endtask

    task automatic wait_drain();
      int n;
      n = 0;
      in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
      while (n < 60) begin
        @(negedge clk);
        if (!busy) break;
        n++;
      end
      chk(gi, "drain_timeout", 64'(busy), 64'd0);
      step();
    endtask

    // Single op on an empty pipe: checks acceptance, latency and a hand-computed result.
    task automatic run_one(mul_opcode_t op, logic [63:0] a, logic [63:0] b, logic [63:0] lit,
                           logic [4:0] tg, string nm);
      int n;
      opcode = op; src1 = W'(a); src2 = W'(b); in_tag = tg;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk(gi, {nm, "_accept"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      n = 1;
      while (n < 10) begin
        @(negedge clk);
        if (out_valid) break;
        step();
        n++;
      end
      chk(gi, {nm, "_latency"}, 64'(n), 64'(L));
      chk(gi, {nm, "_result"}, 64'(out_result), lit);
      chk(gi, {nm, "_tag"}, 64'(out_tag), 64'(tg));
      step();
    endtask

    function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      v = '0;
      case ($urandom_range(0, 4))
        0: v = '0;
        1: v = '1;
        2: v[W-1] = 1'b1;
        3: v[0] = 1'b1;
        default: v = W'({$urandom, $urandom});
      endcase
      return v;
    endfunction

    task automatic rand_op(int t);
      opcode = mul_opcode_t'($urandom_range(0, 2));
      src1 = pick();
      src2 = pick();
      in_tag = 5'(t);
    endtask

    if (gi == 0) begin : g_drv
      initial begin
        init_and_reset();
        run_one(MUL_MUL,   64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0001, 5'd1, "mul_ones");
        run_one(MUL_MULH,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0000, 5'd2, "mulh_ones");
        run_one(MUL_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 5'd3, "mulhu_ones");
        run_one(MUL_MULH,  64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 5'd4, "mulh_min_sq");
        run_one(MUL_MULH,  64'h8000_0000, 64'h0000_0002, 64'hFFFF_FFFF, 5'd5, "mulh_min_x2");
        run_one(MUL_MULHU, 64'h8000_0000, 64'h0000_0002, 64'h0000_0001, 5'd6, "mulhu_min_x2");
        run_one(MUL_MUL,   64'h1234_5678, 64'h0000_0010, 64'h2345_6780, 5'd7, "mul_shift");

        // back-to-back stream
        for (int i = 0; i < 100; i++) begin
          rand_op(i % 32);
          src1 = W'($urandom);
          src2 = W'($urandom);
          in_valid = 1'b1;
          step();
        end
        wait_drain();

        // backpressure fill, then release
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
          rand_op(i + 8);
          in_valid = 1'b1;
          step();
        end
        @(negedge clk);
        chk(gi, "bp_in_ready", 64'(in_ready), 64'd0);
        chk(gi, "bp_fill", 64'(sb.size()), 64'(L));
        step();
        wait_drain();

        // flush with two ops in flight and a third presented
        for (int i = 0; i < 3; i++) begin
          rand_op(i + 20);
          in_valid = 1'b1;
          flush = (i == 2);
          step();
        end
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk(gi, "flush_out_valid", 64'(out_valid), 64'd0);
        chk(gi, "flush_busy", 64'(busy), 64'd0);
        step();
        run_one(MUL_MULHU, 64'hFFFF_FFFF, 64'h0000_0002, 64'h0000_0001, 5'd9, "post_flush");

        // reset mid-stream
        for (int i = 0; i < 4; i++) begin
          rand_op(i + 24);
          in_valid = 1'b1;
          reset = (i == 3);
          step();
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk(gi, "midrst_out_valid", 64'(out_valid), 64'd0);
        chk(gi, "midrst_busy", 64'(busy), 64'd0);
        step();
        run_one(MUL_MUL, 64'h0000_0003, 64'hFFFF_FFFF, 64'hFFFF_FFFD, 5'd10, "post_reset");
        n_done++;
      end
    end else if (gi == 1) begin : g_drv
      initial begin
        int accepted;
        init_and_reset();
        rand_op(0); in_valid = 1'b1; step();
        in_valid = 1'b0; step();
        rand_op(2); in_valid = 1'b1; step();
        out_ready = 1'b0;
        accepted = 2;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (!in_ready) break;
          accepted++;
          step();
          rand_op(i + 3);
        end
        chk(gi, "bubble_held", 64'(accepted), 64'd4);
        chk(gi, "bubble_busy", 64'(busy), 64'd1);
        step();
        wait_drain();
        n_done++;
      end
    end else begin : g_drv
      initial begin
        init_and_reset();
        for (int i = 0; i < 80; i++) begin
          if (i == 41) begin
            reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
            @(negedge clk);
            chk(gi, "sweep_rst_out_valid", 64'(out_valid), 64'd0);
            chk(gi, "sweep_rst_busy", 64'(busy), 64'd0);
            step();
          end
          rand_op(i);
          in_valid  = ($urandom_range(0, 3) != 0);
          out_ready = ($urandom_range(0, 9) < 7);
          flush     = ($urandom_range(0, 24) == 0);
          reset     = (i == 40);
          step();
        end
        wait_drain();
        n_done++;
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (n_done < 8 && t < 30000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < 8) begin
      checks++;
      failures++;
      $display("FAIL timeout: drivers_done=%0d required=8", n_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
